// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz defaults).
// Imported by the timing generator and by the pixel generator so both
// agree on the active area and the line/frame totals.
package vga_pkg;

  localparam int DEF_CLK_DIV  = 2;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Width of a divider counter able to hold 0..div-1 (at least one bit).
  function automatic int div_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel clock divider.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   pix_en  - one-clk strobe on the last system clock of each pixel
//   vga_clk - registered pixel clock for the DAC (high in the upper half
//             of the divider count)
module vga_pix_div
  import vga_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en,
  output logic vga_clk
);

  localparam int DIV_W = div_width(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div;

  assign pix_en = (div == DIV_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      vga_clk <= 1'b0;
    end else begin
      div     <= (div == DIV_MAX) ? '0 : div + 1'b1;
      vga_clk <= (div >= DIV_HALF);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator.
// Stage 0 holds the pixel divider and the horizontal/vertical counters,
// whose values are presented directly on x/y to the pixel generator.
// The output stage registers syncs, blanking and colour once per pixel,
// so everything sent to the DAC lags x/y by exactly one pixel.
// Ports:
//   clk, rst              - system clock, synchronous active-high reset
//   x, y                  - current pixel column / line
//   r_in, g_in, b_in      - colour for the current (x, y)
//   pix_en                - one-clk pixel strobe
//   vga_clk               - DAC pixel clock
//   hsync_n, vsync_n      - active-low syncs
//   blank_n               - low outside the active area
//   sync_n                - composite sync, tied low
//   r, g, b               - registered colour to the DAC
//   frame_start           - one-clk pulse at frame wrap
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [9:0] y,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic       pix_en,
  output logic       vga_clk,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       blank_n,
  output logic       sync_n,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       h_last;
  logic       v_last;
  logic       active;
  logic       hs_zone;
  logic       vs_zone;

  vga_pix_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_div (
    .clk     (clk),
    .rst     (rst),
    .pix_en  (pix_en),
    .vga_clk (vga_clk)
  );

  assign h_last  = (hcnt == H_LAST);
  assign v_last  = (vcnt == V_LAST);
  assign active  = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign hs_zone = (hcnt >= HS_START) && (hcnt < HS_END);
  assign vs_zone = (vcnt >= VS_START) && (vcnt < VS_END);

  assign x      = hcnt;
  assign y      = vcnt;
  assign sync_n = 1'b0;

  // Raster counters: the line counter only moves on the last pixel of a line.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? '0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  // Output stage: samples this pixel's stage-0 decode and holds it for the
  // whole next pixel. frame_start is cleared every clk so that it stays a
  // single-clk pulse even though the rest of the stage holds for CLK_DIV clks.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      blank_n     <= 1'b0;
      r           <= 8'h00;
      g           <= 8'h00;
      b           <= 8'h00;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        hsync_n     <= !hs_zone;
        vsync_n     <= !vs_zone;
        blank_n     <= active;
        r           <= active ? r_in : 8'h00;
        g           <= active ? g_in : 8'h00;
        b           <= active ? b_in : 8'h00;
        frame_start <= h_last && v_last;
      end
    end
  end

endmodule
